// File: rtl/usb_seq_pkg.sv
// Shared types and address constants for the USB access sequencer.
// Address encoding on the slave port is {port, is_cmd}.
package usb_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_GAP,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [1:0] ADDR_HC_DATA = 2'd0;
  localparam logic [1:0] ADDR_HC_CMD  = 2'd1;
  localparam logic [1:0] ADDR_DC_DATA = 2'd2;
  localparam logic [1:0] ADDR_DC_CMD  = 2'd3;

endpackage

// File: rtl/usb_rr_arbiter.sv
// Two-way round-robin arbiter; pointer remembers the last winner.
// On a tie the requester that did not win last time is granted.
module usb_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = req;
    if (req == 2'b11)
      grant = ptr ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ptr <= 1'b1;
    else if (grant_en && |req)
      ptr <= grant[1];
  end

endmodule

// File: rtl/usb_access_sequencer.sv
// Shares the USB OTG slave between two requesters and turns each grant
// into a command write, settling gaps and one or two data accesses.
module usb_access_sequencer
  import usb_seq_pkg::*;
#(
  parameter int GAP_CYCLES = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_req,
  input  logic        r0_port,
  input  logic        r0_write,
  input  logic        r0_wide,
  input  logic [15:0] r0_cmd,
  input  logic [31:0] r0_wdata,
  output logic        r0_ack,
  output logic [31:0] r0_rdata,
  input  logic        r1_req,
  input  logic        r1_port,
  input  logic        r1_write,
  input  logic        r1_wide,
  input  logic [15:0] r1_cmd,
  input  logic [31:0] r1_wdata,
  output logic        r1_ack,
  output logic [31:0] r1_rdata,
  output logic        busy,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [15:0] m_writedata,
  input  logic [15:0] m_readdata
);

  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          who;
  logic          l_port;
  logic          l_write;
  logic          l_wide;
  logic [15:0]   l_cmd;
  logic [31:0]   l_wdata;
  logic [31:0]   rbuf, rbuf_nxt;
  logic          cap;
  logic          cap_slot;
  logic [1:0]    grant;
  logic          remain;
  logic          start;
  logic          finish;

  usb_rr_arbiter u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      ({r1_req, r0_req}),
    .grant_en (state == S_IDLE),
    .grant    (grant)
  );

  assign remain = (idx == 2'd0) || (l_wide && idx == 2'd1);
  assign start  = (state == S_IDLE) && |grant;
  assign finish = (state == S_GAP) && (cnt == '0) && !remain;
  assign busy   = (state != S_IDLE);
  assign r0_ack = (state == S_DONE) && !who;
  assign r1_ack = (state == S_DONE) && who;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_CMD;
      S_CMD:  state_nxt = S_GAP;
      S_GAP:  if (cnt == '0) state_nxt = remain ? S_DATA : S_DONE;
      S_DATA: state_nxt = S_GAP;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    m_chipselect = 1'b0;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_address    = 2'd0;
    m_writedata  = 16'd0;
    if (state == S_CMD) begin
      m_chipselect = 1'b1;
      m_write      = 1'b1;
      m_address    = l_port ? ADDR_DC_CMD : ADDR_HC_CMD;
      m_writedata  = l_cmd;
    end else if (state == S_DATA) begin
      m_chipselect = 1'b1;
      m_address    = l_port ? ADDR_DC_DATA : ADDR_HC_DATA;
      m_read       = !l_write;
      m_write      = l_write;
      if (l_write)
        m_writedata = idx[0] ? l_wdata[31:16] : l_wdata[15:0];
    end
  end

  // Slave returns read data the cycle after the strobe.
  always_comb begin
    rbuf_nxt = rbuf;
    if (state == S_GAP && cap) begin
      if (cap_slot) rbuf_nxt[31:16] = m_readdata;
      else          rbuf_nxt[15:0]  = m_readdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= 2'd0;
      who      <= 1'b0;
      l_port   <= 1'b0;
      l_write  <= 1'b0;
      l_wide   <= 1'b0;
      l_cmd    <= 16'd0;
      l_wdata  <= 32'd0;
      rbuf     <= 32'd0;
      cap      <= 1'b0;
      cap_slot <= 1'b0;
      r0_rdata <= 32'd0;
      r1_rdata <= 32'd0;
    end else begin
      state <= state_nxt;
      rbuf  <= rbuf_nxt;
      cap   <= (state == S_DATA) && !l_write;
      if (start) begin
        who     <= grant[1];
        l_port  <= grant[1] ? r1_port  : r0_port;
        l_write <= grant[1] ? r1_write : r0_write;
        l_wide  <= grant[1] ? r1_wide  : r0_wide;
        l_cmd   <= grant[1] ? r1_cmd   : r0_cmd;
        l_wdata <= grant[1] ? r1_wdata : r0_wdata;
        idx     <= 2'd0;
        rbuf    <= 32'd0;
      end
      if (state == S_CMD || state == S_DATA)
        cnt <= GAP_LOAD;
      else if (state == S_GAP && cnt != '0)
        cnt <= cnt - 1'b1;
      if (state == S_DATA) begin
        idx      <= idx + 2'd1;
        cap_slot <= idx[0];
      end
      // Result lands as DONE is entered so it is valid with the ack.
      if (finish && !l_write) begin
        if (who)
          r1_rdata <= l_wide ? rbuf_nxt : {16'd0, rbuf_nxt[15:0]};
        else
          r0_rdata <= l_wide ? rbuf_nxt : {16'd0, rbuf_nxt[15:0]};
      end
    end
  end

endmodule
